// File: rtl/ysyx_24110006_lsu.sv
// Load/store stage: one bus transaction per load/store, lane alignment of store
// data/strobes, load extension, misalign/fault exceptions, writeback bundle out.
module ysyx_24110006_lsu #(
    parameter int          XLEN        = 32,
    parameter logic [3:0]  MCAUSE_LMIS = 4'd4,
    parameter logic [3:0]  MCAUSE_LFLT = 4'd5,
    parameter logic [3:0]  MCAUSE_SMIS = 4'd6,
    parameter logic [3:0]  MCAUSE_SFLT = 4'd7
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_result,
    input  logic            i_mem_ren,
    input  logic            i_mem_wen,
    input  logic [3:0]      i_mem_wmask,
    input  logic [2:0]      i_mem_read_t,
    input  logic [XLEN-1:0] i_mem_wdata,
    input  logic [4:0]      i_reg_rd,
    input  logic            i_reg_wen,
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_csr_t,
    input  logic [11:0]     i_csr,
    input  logic            i_exception,
    input  logic [3:0]      i_mcause,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_reg_rd,
    output logic            o_reg_wen,
    output logic [XLEN-1:0] o_pc,
    output logic [1:0]      o_csr_t,
    output logic [11:0]     o_csr,
    output logic            o_exception,
    output logic [3:0]      o_mcause,
    output logic [XLEN-1:0] o_badaddr,
    output logic            o_bus_req_valid,
    input  logic            i_bus_req_ready,
    output logic [XLEN-1:0] o_bus_addr,
    output logic            o_bus_wen,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_wstrb,
    output logic [1:0]      o_bus_size,
    input  logic            i_bus_resp_valid,
    output logic            o_bus_resp_ready,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic        accept;
    logic        is_store;
    logic        is_mem;
    logic [1:0]  in_size;
    logic        in_misaligned;
    logic        issue;
    logic        killed;
    logic [2:0]  read_type;

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [1:0]      offset,
                                                    input logic [2:0]      rtype);
        logic [XLEN-1:0] shifted;
        shifted = rdata >> {offset, 3'b000};
        case (rtype)
            3'b000:  load_extend = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_extend = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_extend = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_extend = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_extend = shifted;
        endcase
    endfunction

    assign o_ready          = (state == IDLE) | ((state == DONE) & i_ready);
    assign accept           = i_valid & o_ready & ~i_flush;
    assign o_valid          = (state == DONE);
    assign o_bus_req_valid  = (state == REQ);
    assign o_bus_resp_ready = (state == WAIT);

    // Access width: loads decode funct3, stores decode the byte mask.
    always_comb begin
        in_size = 2'd2;
        if (i_mem_ren) begin
            case (i_mem_read_t[1:0])
                2'b00:   in_size = 2'd0;
                2'b01:   in_size = 2'd1;
                default: in_size = 2'd2;
            endcase
        end else begin
            case (i_mem_wmask)
                4'b0001: in_size = 2'd0;
                4'b0011: in_size = 2'd1;
                default: in_size = 2'd2;
            endcase
        end
    end

    assign is_store      = i_mem_wen & ~i_mem_ren;
    assign is_mem        = i_mem_ren | i_mem_wen;
    assign in_misaligned = ((in_size == 2'd1) & i_result[0]) |
                           ((in_size == 2'd2) & (|i_result[1:0]));
    assign issue         = ~i_exception & is_mem & ~in_misaligned;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = issue ? REQ : DONE;
            REQ: begin
                if (i_bus_req_ready) state_next = WAIT;
                else if (i_flush)    state_next = IDLE;
            end
            WAIT: if (i_bus_resp_valid) state_next = (killed | i_flush) ? IDLE : DONE;
            DONE: begin
                if (i_flush | i_ready) begin
                    if (accept) state_next = issue ? REQ : DONE;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_result    <= '0;
            o_reg_rd    <= '0;
            o_reg_wen   <= 1'b0;
            o_pc        <= '0;
            o_csr_t     <= '0;
            o_csr       <= '0;
            o_exception <= 1'b0;
            o_mcause    <= '0;
            o_badaddr   <= '0;
            o_bus_addr  <= '0;
            o_bus_wen   <= 1'b0;
            o_bus_wdata <= '0;
            o_bus_wstrb <= '0;
            o_bus_size  <= '0;
            read_type   <= '0;
            killed      <= 1'b0;
        end else begin
            if (accept) begin
                o_result    <= i_result;
                o_reg_rd    <= i_reg_rd;
                o_reg_wen   <= i_reg_wen & ~(issue & is_store);
                o_pc        <= i_pc;
                o_csr_t     <= i_csr_t;
                o_csr       <= i_csr;
                o_exception <= i_exception;
                o_mcause    <= i_mcause;
                o_badaddr   <= '0;
                o_bus_addr  <= i_result;
                o_bus_wen   <= issue & is_store;
                o_bus_wdata <= i_mem_wdata << {i_result[1:0], 3'b000};
                o_bus_wstrb <= (issue & is_store) ? (i_mem_wmask << i_result[1:0]) : 4'b0000;
                o_bus_size  <= in_size;
                read_type   <= i_mem_read_t;
                killed      <= 1'b0;
                if (~i_exception & is_mem & in_misaligned) begin
                    o_exception <= 1'b1;
                    o_mcause    <= i_mem_ren ? MCAUSE_LMIS : MCAUSE_SMIS;
                    o_badaddr   <= i_result;
                    o_reg_wen   <= 1'b0;
                end
            end
            // A flush after the request handshake must still drain the response.
            if (state == REQ && i_bus_req_ready) killed <= i_flush;
            if (state == WAIT) begin
                if (i_flush) killed <= 1'b1;
                if (i_bus_resp_valid) begin
                    if (i_bus_resp_err) begin
                        o_exception <= 1'b1;
                        o_mcause    <= o_bus_wen ? MCAUSE_SFLT : MCAUSE_LFLT;
                        o_badaddr   <= o_bus_addr;
                        o_reg_wen   <= 1'b0;
                    end else if (o_bus_wen) begin
                        o_result <= o_bus_addr;
                    end else begin
                        o_result <= load_extend(i_bus_rdata, o_bus_addr[1:0], read_type);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Directed bench for ysyx_24110006_lsu: vector table plus handshake corner sequences.
module tb_ysyx_24110006_lsu;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid, o_ready, i_flush;
    logic [31:0] i_result;
    logic        i_mem_ren, i_mem_wen;
    logic [3:0]  i_mem_wmask;
    logic [2:0]  i_mem_read_t;
    logic [31:0] i_mem_wdata;
    logic [4:0]  i_reg_rd;
    logic        i_reg_wen;
    logic [31:0] i_pc;
    logic [1:0]  i_csr_t;
    logic [11:0] i_csr;
    logic        i_exception;
    logic [3:0]  i_mcause;
    logic        o_valid, i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_reg_rd;
    logic        o_reg_wen;
    logic [31:0] o_pc;
    logic [1:0]  o_csr_t;
    logic [11:0] o_csr;
    logic        o_exception;
    logic [3:0]  o_mcause;
    logic [31:0] o_badaddr;
    logic        o_bus_req_valid, i_bus_req_ready;
    logic [31:0] o_bus_addr;
    logic        o_bus_wen;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    logic [1:0]  o_bus_size;
    logic        i_bus_resp_valid, o_bus_resp_ready;
    logic [31:0] i_bus_rdata;
    logic        i_bus_resp_err;

    int compared = 0;
    int mismatched = 0;

    ysyx_24110006_lsu dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_result(i_result), .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen),
        .i_mem_wmask(i_mem_wmask), .i_mem_read_t(i_mem_read_t), .i_mem_wdata(i_mem_wdata),
        .i_reg_rd(i_reg_rd), .i_reg_wen(i_reg_wen), .i_pc(i_pc), .i_csr_t(i_csr_t),
        .i_csr(i_csr), .i_exception(i_exception), .i_mcause(i_mcause), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_reg_rd(o_reg_rd), .o_reg_wen(o_reg_wen),
        .o_pc(o_pc), .o_csr_t(o_csr_t), .o_csr(o_csr), .o_exception(o_exception),
        .o_mcause(o_mcause), .o_badaddr(o_badaddr), .o_bus_req_valid(o_bus_req_valid),
        .i_bus_req_ready(i_bus_req_ready), .o_bus_addr(o_bus_addr), .o_bus_wen(o_bus_wen),
        .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb), .o_bus_size(o_bus_size),
        .i_bus_resp_valid(i_bus_resp_valid), .o_bus_resp_ready(o_bus_resp_ready),
        .i_bus_rdata(i_bus_rdata), .i_bus_resp_err(i_bus_resp_err)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        ren, wen;
        logic [3:0]  wmask;
        logic [2:0]  rt;
        logic [31:0] addr, wdata, rdata;
        logic        err, exc_in;
        logic [3:0]  mc_in;
        logic        bus;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] bwdata, res;
        logic        rwen, exc;
        logic [3:0]  mc;
        logic [31:0] bad;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [3:0] wmask,
                         input logic [2:0] rt, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exc, input logic [3:0] mc, input logic [4:0] rd);
        i_valid      = 1'b1;
        i_mem_ren    = ren;
        i_mem_wen    = wen;
        i_mem_wmask  = wmask;
        i_mem_read_t = rt;
        i_result     = addr;
        i_mem_wdata  = wdata;
        i_exception  = exc;
        i_mcause     = mc;
        i_reg_rd     = rd;
        i_reg_wen    = 1'b1;
        i_pc         = 32'h8000_1000 + {27'd0, rd};
    endtask

    task automatic do_load_issue(input logic [31:0] addr);
        @(negedge i_clock);
        drive(1'b1, 1'b0, 4'hF, 3'b010, addr, 32'h0, 1'b0, 4'h0, 5'd9);
        @(negedge i_clock);
        i_valid = 1'b0;
        i_bus_req_ready = 1'b1;
        @(negedge i_clock);
        i_bus_req_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1,0,4'h1,3'b000,32'h80000003,32'h0,32'h80FF1234,0,0,4'h0,1,2'd0,4'h0,32'h0,32'hFFFFFF80,1,0,4'h0,32'h0};
        vecs[1]  = '{1,0,4'h3,3'b101,32'h80000002,32'h0,32'h80FF1234,0,0,4'h0,1,2'd1,4'h0,32'h0,32'h000080FF,1,0,4'h0,32'h0};
        vecs[2]  = '{1,0,4'h3,3'b001,32'h80000002,32'h0,32'h80FF1234,0,0,4'h0,1,2'd1,4'h0,32'h0,32'hFFFF80FF,1,0,4'h0,32'h0};
        vecs[3]  = '{1,0,4'h1,3'b100,32'h80000001,32'h0,32'h80FF9A34,0,0,4'h0,1,2'd0,4'h0,32'h0,32'h0000009A,1,0,4'h0,32'h0};
        vecs[4]  = '{1,0,4'hF,3'b010,32'h80000004,32'h0,32'hDEADBEEF,0,0,4'h0,1,2'd2,4'h0,32'h0,32'hDEADBEEF,1,0,4'h0,32'h0};
        vecs[5]  = '{0,1,4'h1,3'b010,32'h80000101,32'h000000AB,32'h0,0,0,4'h0,1,2'd0,4'h2,32'h0000AB00,32'h80000101,0,0,4'h0,32'h0};
        vecs[6]  = '{0,1,4'h3,3'b010,32'h80000102,32'h00001234,32'h0,0,0,4'h0,1,2'd1,4'hC,32'h12340000,32'h80000102,0,0,4'h0,32'h0};
        vecs[7]  = '{0,1,4'hF,3'b010,32'h80000102,32'h00000055,32'h0,0,0,4'h0,0,2'd2,4'h0,32'h0,32'h80000102,0,1,4'h6,32'h80000102};
        vecs[8]  = '{1,0,4'hF,3'b010,32'h80000010,32'h0,32'h0,1,0,4'h0,1,2'd2,4'h0,32'h0,32'h80000010,0,1,4'h5,32'h80000010};
        vecs[9]  = '{0,1,4'hF,3'b010,32'h80000020,32'hCAFEF00D,32'h0,1,0,4'h0,1,2'd2,4'hF,32'hCAFEF00D,32'h80000020,0,1,4'h7,32'h80000020};
        vecs[10] = '{1,0,4'h3,3'b001,32'h80000001,32'h0,32'h0,0,0,4'h0,0,2'd1,4'h0,32'h0,32'h80000001,0,1,4'h4,32'h80000001};
        vecs[11] = '{0,0,4'h0,3'b000,32'h12345678,32'h0,32'h0,0,0,4'h0,0,2'd0,4'h0,32'h0,32'h12345678,1,0,4'h0,32'h0};
        vecs[12] = '{1,0,4'h3,3'b001,32'h80000001,32'h0,32'h0,0,1,4'h2,0,2'd1,4'h0,32'h0,32'h80000001,1,1,4'h2,32'h0};

        i_reset = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_result = '0;
        i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_mem_wmask = '0; i_mem_read_t = '0;
        i_mem_wdata = '0; i_reg_rd = '0; i_reg_wen = 1'b0; i_pc = '0; i_csr_t = '0;
        i_csr = '0; i_exception = 1'b0; i_mcause = '0; i_ready = 1'b1;
        i_bus_req_ready = 1'b0; i_bus_resp_valid = 1'b0; i_bus_rdata = '0; i_bus_resp_err = 1'b0;

        // Reset state
        @(negedge i_clock);
        @(negedge i_clock);
        chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_req_valid", {31'd0, o_bus_req_valid}, 32'd0);
        chk("rst_o_result", o_result, 32'd0);
        chk("rst_wstrb", {28'd0, o_bus_wstrb}, 32'd0);
        i_reset = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 13; i++) begin
            @(negedge i_clock);
            drive(vecs[i].ren, vecs[i].wen, vecs[i].wmask, vecs[i].rt, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exc_in, vecs[i].mc_in, 5'(i + 1));
            @(negedge i_clock);
            i_valid = 1'b0;
            chk($sformatf("v%0d_req_valid", i), {31'd0, o_bus_req_valid}, {31'd0, vecs[i].bus});
            if (vecs[i].bus) begin
                chk($sformatf("v%0d_addr", i), o_bus_addr, vecs[i].addr);
                chk($sformatf("v%0d_size", i), {30'd0, o_bus_size}, {30'd0, vecs[i].size});
                chk($sformatf("v%0d_bwen", i), {31'd0, o_bus_wen}, {31'd0, vecs[i].wen});
                chk($sformatf("v%0d_wstrb", i), {28'd0, o_bus_wstrb}, {28'd0, vecs[i].wstrb});
                if (vecs[i].wen) chk($sformatf("v%0d_wdata", i), o_bus_wdata, vecs[i].bwdata);
                i_bus_req_ready = 1'b1;
                @(negedge i_clock);
                i_bus_req_ready = 1'b0;
                chk($sformatf("v%0d_resp_ready", i), {31'd0, o_bus_resp_ready}, 32'd1);
                i_bus_resp_valid = 1'b1;
                i_bus_rdata = vecs[i].rdata;
                i_bus_resp_err = vecs[i].err;
                @(negedge i_clock);
                i_bus_resp_valid = 1'b0;
                i_bus_resp_err = 1'b0;
            end
            chk($sformatf("v%0d_o_valid", i), {31'd0, o_valid}, 32'd1);
            chk($sformatf("v%0d_result", i), o_result, vecs[i].res);
            chk($sformatf("v%0d_reg_wen", i), {31'd0, o_reg_wen}, {31'd0, vecs[i].rwen});
            chk($sformatf("v%0d_exception", i), {31'd0, o_exception}, {31'd0, vecs[i].exc});
            chk($sformatf("v%0d_mcause", i), {28'd0, o_mcause}, {28'd0, vecs[i].mc});
            chk($sformatf("v%0d_badaddr", i), o_badaddr, vecs[i].bad);
            chk($sformatf("v%0d_reg_rd", i), {27'd0, o_reg_rd}, 32'(i + 1));
        end

        // Back-pressure on request and on downstream
        @(negedge i_clock);
        drive(1'b1, 1'b0, 4'hF, 3'b010, 32'h80000040, 32'h0, 1'b0, 4'h0, 5'd20);
        @(negedge i_clock);
        i_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_req_valid", {31'd0, o_bus_req_valid}, 32'd1);
            chk("bp_req_addr", o_bus_addr, 32'h80000040);
            chk("bp_req_size", {30'd0, o_bus_size}, 32'd2);
            @(negedge i_clock);
        end
        chk("bp_req_valid_last", {31'd0, o_bus_req_valid}, 32'd1);
        i_bus_req_ready = 1'b1;
        @(negedge i_clock);
        i_bus_req_ready = 1'b0;
        i_bus_resp_valid = 1'b1;
        i_bus_rdata = 32'h0BADF00D;
        i_ready = 1'b0;
        @(negedge i_clock);
        i_bus_resp_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("bp_o_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_o_ready", {31'd0, o_ready}, 32'd0);
            chk("bp_result", o_result, 32'h0BADF00D);
            @(negedge i_clock);
        end
        chk("bp_o_valid_held", {31'd0, o_valid}, 32'd1);
        i_ready = 1'b1;
        @(negedge i_clock);
        chk("bp_release", {31'd0, o_valid}, 32'd0);

        // Back-to-back non-memory bundles
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                chk("b2b_o_valid", {31'd0, o_valid}, 32'd1);
                chk("b2b_o_ready", {31'd0, o_ready}, 32'd1);
                chk("b2b_result", o_result, 32'h1000 + 32'(k - 1));
            end
            drive(1'b0, 1'b0, 4'h0, 3'b000, 32'h1000 + 32'(k), 32'h0, 1'b0, 4'h0, 5'd1);
            @(negedge i_clock);
        end
        i_valid = 1'b0;
        chk("b2b_last_result", o_result, 32'h1003);
        chk("b2b_last_valid", {31'd0, o_valid}, 32'd1);
        @(negedge i_clock);

        // Flush while waiting for the response
        do_load_issue(32'h80000080);
        chk("flw_resp_ready", {31'd0, o_bus_resp_ready}, 32'd1);
        i_flush = 1'b1;
        @(negedge i_clock);
        i_flush = 1'b0;
        chk("flw_still_waiting", {31'd0, o_bus_resp_ready}, 32'd1);
        i_bus_resp_valid = 1'b1;
        i_bus_rdata = 32'h12345678;
        @(negedge i_clock);
        i_bus_resp_valid = 1'b0;
        chk("flw_no_valid", {31'd0, o_valid}, 32'd0);
        chk("flw_idle_ready", {31'd0, o_ready}, 32'd1);
        @(negedge i_clock);
        chk("flw_no_valid_later", {31'd0, o_valid}, 32'd0);

        // Flush in REQ before the handshake
        @(negedge i_clock);
        drive(1'b1, 1'b0, 4'hF, 3'b010, 32'h80000090, 32'h0, 1'b0, 4'h0, 5'd3);
        @(negedge i_clock);
        i_valid = 1'b0;
        chk("flr_req_valid", {31'd0, o_bus_req_valid}, 32'd1);
        i_flush = 1'b1;
        @(negedge i_clock);
        i_flush = 1'b0;
        chk("flr_req_dropped", {31'd0, o_bus_req_valid}, 32'd0);
        chk("flr_idle_ready", {31'd0, o_ready}, 32'd1);

        // Asynchronous reset in the middle of WAIT
        do_load_issue(32'h800000A0);
        chk("rstw_resp_ready", {31'd0, o_bus_resp_ready}, 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("rstw_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rstw_o_ready", {31'd0, o_ready}, 32'd1);
        chk("rstw_resp_ready_off", {31'd0, o_bus_resp_ready}, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        chk("rstw_stays_idle", {31'd0, o_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_lsu.md
Name: ysyx_24110006_lsu

Overview:
Load/store stage that consumes the execute stage's memory-request outputs over the pipeline valid/ready handshake. It issues one request/response bus transaction per load or store, with byte-lane alignment of store data and strobes, and sign/zero extension of load data. It detects misaligned and faulting accesses and raises exceptions, then presents a writeback bundle downstream. Non-memory instructions pass through with one cycle of latency.

Parameters:
XLEN, 32, data/address width
MCAUSE_LMIS, 4, load address misaligned cause
MCAUSE_LFLT, 5, load access fault cause
MCAUSE_SMIS, 6, store address misaligned cause
MCAUSE_SFLT, 7, store access fault cause

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-low
i_valid  in  1  upstream bundle valid
o_ready  out 1  upstream may transfer
i_flush  in  1  kill in-flight/incoming instruction
i_result  in 32  ALU result; address when mem op
i_mem_ren, i_mem_wen  in 1 each  load / store
i_mem_wmask  in 4  unshifted mask: 0001/0011/1111
i_mem_read_t  in 3  load funct3
i_mem_wdata  in 32  unshifted store data
i_reg_rd  in 5;  i_reg_wen  in 1;  i_pc  in 32;  i_csr_t  in 2;  i_csr  in 12
i_exception  in 1;  i_mcause  in 4
o_valid  out 1;  i_ready  in 1  downstream handshake
o_result  out 32  writeback value
o_reg_rd  out 5;  o_reg_wen  out 1;  o_pc  out 32;  o_csr_t  out 2;  o_csr  out 12
o_exception  out 1;  o_mcause  out 4;  o_badaddr  out 32
o_bus_req_valid  out 1;  i_bus_req_ready  in 1
o_bus_addr  out 32;  o_bus_wen  out 1;  o_bus_wdata  out 32;  o_bus_wstrb  out 4;  o_bus_size  out 2
i_bus_resp_valid  in 1;  o_bus_resp_ready  out 1;  i_bus_rdata  in 32;  i_bus_resp_err  in 1

Behaviour:
- States: IDLE, REQ, WAIT, DONE. On reset (i_reset=0, asynchronous): state=IDLE. All outputs are 0 except o_ready=1.
- o_ready = (IDLE) | (DONE & i_ready). The stage accepts a bundle when i_valid & o_ready & ~i_flush. On accept it latches all inputs.
- On accept, next state is chosen as follows:
  - i_exception set: DONE, passthrough, no bus activity.
  - Neither ren nor wen: DONE. o_result = i_result.
  - Misaligned access: DONE. o_exception=1, o_mcause=LMIS or SMIS, o_badaddr=addr, o_reg_wen=0, no bus activity. Halfword is misaligned when addr[0]=1. Word is misaligned when addr[1:0]≠0. Width comes from read_t[1:0] or wmask.
  - Otherwise: REQ.
- REQ: o_bus_req_valid=1 and bus fields stay stable until i_bus_req_ready, then go to WAIT.
  - o_bus_addr = full address.
  - o_bus_size = 0/1/2 for byte/half/word.
  - o_bus_wstrb = wmask<<addr[1:0] for stores, 0 for loads.
  - o_bus_wdata = wdata<<(8*addr[1:0]).
- WAIT: o_bus_resp_ready=1. On i_bus_resp_valid go to DONE.
  - Load result: rdata>>(8*addr[1:0]), then extended by read_t. 000 lb sign-extends bit7. 001 lh sign-extends bit15. 100 lbu and 101 lhu zero-extend. 010 and any other code take the full word.
  - Store result: o_result = address; o_reg_wen is already 0.
  - i_bus_resp_err: exception with LFLT or SFLT, o_badaddr=addr, o_reg_wen=0.
- DONE: o_valid=1 and all outputs hold until i_ready. A new bundle may be accepted in the same cycle as the downstream transfer (back-to-back, no bubble).
- Minimum latency: non-mem 1 cycle. Memory ops take 1 + request wait + response wait cycles.
- i_flush handling:
  - In IDLE or DONE-transfer cycle: the incoming bundle is dropped.
  - In REQ before handshake: return to IDLE, no bus request completes.
  - In REQ on the same cycle as i_bus_req_ready: the transaction counts as issued and proceeds to WAIT.
  - In WAIT: the response is still consumed (stores complete on the bus), the result is discarded, and the next state is IDLE (o_valid never rises).
  - In DONE: o_valid drops next cycle.
- Only one outstanding bus transaction at a time. o_bus_req_valid is never asserted outside REQ.

Test Plan:
- lb, addr 0x80000003, rdata 0x80FF1234 -> o_result 0xFFFFFF80, o_reg_wen 1, o_bus_size 0.
- lhu addr 0x80000002, rdata 0x80FF1234 -> o_result 0x000080FF. lh same -> 0xFFFF80FF.
- sb wdata 0x000000AB, wmask 0001, addr 0x80000101 -> o_bus_wdata 0x0000AB00, o_bus_wstrb 0010, o_bus_wen 1.
- sw addr 0x80000102 -> no o_bus_req_valid; o_valid with o_exception 1, o_mcause 6, o_badaddr 0x80000102. A load response with i_bus_resp_err -> o_mcause 5.
- Back-pressure: i_bus_req_ready low 3 cycles then i_ready low 2 cycles -> bus fields and outputs stable throughout. Back-to-back addi bundles -> one output per cycle.
- i_flush in WAIT -> response consumed, no o_valid. Reset asserted mid-WAIT -> immediate IDLE, o_valid 0, o_ready 1.
